mouse_cursor: RTL and testbench

- Consumes the 28-bit PS/2 mouse status word {run, btns[2:0], 0, y[10:0], 0, x[10:0]}, where x/y are free-running, wrapping 11-bit accumulators.
- Converts the status word into an absolute screen cursor: takes modular deltas, inverts Y for screen orientation, and clamps to the display bounds.
- Queues position/button-change events in a small FIFO with a valid/ready handshake, for the CPU IO register or the sprite overlay.

---
 rtl/mouse_cursor.sv | 210 +++++++++++++++++++++
 tb/tb_mouse_cursor.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mouse_cursor.sv
// rtl/mouse_cursor.sv - PS/2 status word to clamped absolute cursor with an event FIFO (optional MOUSE_ACCEL_EN)
module mouse_cursor #(
    parameter int H_RES        = 1024,
    parameter int V_RES        = 768,
    parameter int FIFO_DEPTH   = 4,
    parameter int ACCEL_THRESH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [27:0] mouse,
    output logic [10:0] cur_x,
    output logic [10:0] cur_y,
    output logic [2:0]  btns,
    output logic        mouse_run,
    output logic        ev_valid,
    output logic [24:0] ev_data,
    input  logic        ev_ready,
    output logic        ev_overflow
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [10:0]        X_CENTRE = 11'(H_RES / 2);
    localparam logic [10:0]        Y_CENTRE = 11'(V_RES / 2);
    localparam logic signed [12:0] X_MAX    = 13'(H_RES - 1);
    localparam logic signed [12:0] Y_MAX    = 13'(V_RES - 1);
    localparam logic [CW-1:0]      FULL_CNT = CW'(FIFO_DEPTH);

    // Status word fields.
    logic        m_run;
    logic [2:0]  m_btns;
    logic [10:0] m_x;
    logic [10:0] m_y;

    assign m_run  = mouse[27];
    assign m_btns = mouse[26:24];
    assign m_y    = mouse[22:12];
    assign m_x    = mouse[10:0];

    // Stage 1 state.
    logic        s1_run;
    logic [2:0]  s1_btns;
    logic [10:0] s1_dx;
    logic [10:0] s1_dy;
    logic [10:0] prev_x;
    logic [10:0] prev_y;

    // Stage 1: modular deltas against the previous accumulator sample; idle while not running.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_run  <= 1'b0;
            s1_btns <= 3'b000;
            s1_dx   <= 11'd0;
            s1_dy   <= 11'd0;
            prev_x  <= 11'd0;
            prev_y  <= 11'd0;
        end else begin
            s1_run  <= m_run;
            s1_btns <= m_btns;
            if (m_run) begin
                s1_dx  <= m_x - prev_x;
                s1_dy  <= m_y - prev_y;
                prev_x <= m_x;
                prev_y <= m_y;
            end else begin
                s1_dx  <= 11'd0;
                s1_dy  <= 11'd0;
                prev_x <= 11'd0;
                prev_y <= 11'd0;
            end
        end
    end

    // Sign-extend a delta to the 13-bit working width, doubling large moves when acceleration is built in.
    function automatic logic signed [12:0] eff_delta(input logic [10:0] d);
        logic signed [12:0] d13;
`ifdef MOUSE_ACCEL_EN
        logic signed [11:0] d12;
        logic        [11:0] mag;
`endif
        d13 = {{2{d[10]}}, d};
`ifdef MOUSE_ACCEL_EN
        d12 = {d[10], d};
        mag = d12[11] ? 12'(-d12) : 12'(d12);
        if (int'(mag) > ACCEL_THRESH) begin
            d13 = d13 <<< 1;
        end
`endif
        return d13;
    endfunction

    // Stage 2 combinational next position and change detection.
    logic signed [12:0] dx_eff;
    logic signed [12:0] dy_eff;
    logic signed [12:0] nx;
    logic signed [12:0] ny;
    logic [10:0]        nx_c;
    logic [10:0]        ny_c;
    logic [24:0]        new_ev;
    logic               changed;

    // Add/subtract the deltas (+Y is up, so it lowers the row) and clamp to the screen.
    always_comb begin
        dx_eff = eff_delta(s1_dx);
        dy_eff = eff_delta(s1_dy);
        nx     = $signed({2'b00, cur_x}) + dx_eff;
        ny     = $signed({2'b00, cur_y}) - dy_eff;
        nx_c   = nx[10:0];
        ny_c   = ny[10:0];
        if (nx < 13'sd0) begin
            nx_c = 11'd0;
        end else if (nx > X_MAX) begin
            nx_c = X_MAX[10:0];
        end
        if (ny < 13'sd0) begin
            ny_c = 11'd0;
        end else if (ny > Y_MAX) begin
            ny_c = Y_MAX[10:0];
        end
        new_ev  = {s1_btns, ny_c, nx_c};
        changed = (new_ev != {btns, cur_y, cur_x});
    end

    // Stage 2 registers plus the pending-event register that feeds the FIFO one clock later.
    logic        ev_pend;
    logic [24:0] ev_pend_data;

    // Stage 2: commit cursor and buttons, and flag an event whenever the visible state changed.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_x        <= X_CENTRE;
            cur_y        <= Y_CENTRE;
            btns         <= 3'b000;
            mouse_run    <= 1'b0;
            ev_pend      <= 1'b0;
            ev_pend_data <= 25'd0;
        end else begin
            cur_x        <= nx_c;
            cur_y        <= ny_c;
            btns         <= s1_btns;
            mouse_run    <= s1_run;
            ev_pend      <= changed;
            ev_pend_data <= new_ev;
        end
    end

    // Event FIFO, first-word-fall-through.
    logic [24:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] last_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          pop;
    logic          push_norm;
    logic          push_coal;
    logic          wr_en;
    logic [AW-1:0] wr_idx;

    // Decide between an ordinary append and coalescing into the newest entry when full.
    always_comb begin
        full      = (count == FULL_CNT);
        pop       = ev_valid & ev_ready;
        last_ptr  = wr_ptr - AW'(1);
        push_norm = ev_pend & (~full | pop);
        push_coal = ev_pend & full & ~pop;
        wr_en     = push_norm | push_coal;
        wr_idx    = push_coal ? last_ptr : wr_ptr;
    end

    // Entry storage; contents need no reset because the output is gated by occupancy.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_idx] <= ev_pend_data;
        end
    end

    // Pointers, occupancy and the sticky lost-button-transition flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            ev_overflow <= 1'b0;
        end else begin
            if (push_norm) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_norm && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push_norm) begin
                count <= count - CW'(1);
            end
            if (push_coal && (mem[last_ptr][24:22] != ev_pend_data[24:22])) begin
                ev_overflow <= 1'b1;
            end
        end
    end

    // Head of queue is presented while non-empty; zero otherwise.
    always_comb begin
        ev_valid = (count != '0);
        ev_data  = ev_valid ? mem[rd_ptr] : 25'd0;
    end

endmodule

// File: tb/tb_mouse_cursor.sv
// tb/tb_mouse_cursor.sv - scoreboard bench for mouse_cursor
module tb_mouse_cursor;

    logic        clk = 1'b0;
    logic        rst;
    logic [27:0] mouse;
    logic [10:0] cur_x;
    logic [10:0] cur_y;
    logic [2:0]  btns;
    logic        mouse_run;
    logic        ev_valid;
    logic [24:0] ev_data;
    logic        ev_ready;
    logic        ev_overflow;

    int checks = 0;
    int passes = 0;
    logic [24:0] sb[$];

    mouse_cursor dut (
        .clk         (clk),
        .rst         (rst),
        .mouse       (mouse),
        .cur_x       (cur_x),
        .cur_y       (cur_y),
        .btns        (btns),
        .mouse_run   (mouse_run),
        .ev_valid    (ev_valid),
        .ev_data     (ev_data),
        .ev_ready    (ev_ready),
        .ev_overflow (ev_overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [27:0] mk(input logic run, input logic [2:0] b,
                                       input logic [10:0] y, input logic [10:0] x);
        return {run, b, 1'b0, y, 1'b0, x};
    endfunction

    function automatic logic [24:0] ev(input logic [2:0] b, input int y, input int x);
        return {b, 11'(y), 11'(x)};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Drive a new status word, record the expected event if any, and let the pipeline settle.
    task automatic mv(input logic [27:0] w, input bit pe, input logic [24:0] e);
        mouse = w;
        if (pe) sb.push_back(e);
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted event is checked against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && ev_valid && ev_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_event", int'(ev_data), -1);
            end else begin
                chk("event", int'(ev_data), int'(sb[0]));
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    int xe;

    initial begin
        rst = 1'b1;
        mouse = 28'd0;
        ev_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cur_x", cur_x, 512);
        chk("rst_cur_y", cur_y, 384);
        chk("rst_btns", btns, 0);
        chk("rst_run", mouse_run, 0);
        chk("rst_valid", ev_valid, 0);
        chk("rst_data", ev_data, 0);
        chk("rst_ovf", ev_overflow, 0);

        rst = 1'b0;
        mouse = 28'h8000000;
        repeat (4) @(posedge clk);
        #1;
        chk("idle_cur_x", cur_x, 512);
        chk("idle_valid", ev_valid, 0);
        chk("idle_run", mouse_run, 1);

        // Single move with latency check.
        mouse = mk(1, 0, 0, 10);
        sb.push_back(ev(0, 384, 522));
        repeat (2) @(posedge clk);
        #1;
        chk("move_cur_x_n2", cur_x, 522);
        chk("move_valid_n2", ev_valid, 0);
        @(posedge clk);
        #1;
        chk("move_valid_n3", ev_valid, 1);
        chk("move_data_n3", ev_data, ev(0, 384, 522));
        ev_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("move_popped", ev_valid, 0);

        // Accumulator wrap in both axes.
        mv(mk(1, 0, 0, 11'h7FE), 1, ev(0, 384, 510));
        chk("wrap_x_back", cur_x, 510);
        mv(mk(1, 0, 0, 11'h002), 1, ev(0, 384, 514));
        chk("wrap_x_fwd", cur_x, 514);
        mv(mk(1, 0, 11'h001, 11'h002), 1, ev(0, 383, 514));
        chk("y_up", cur_y, 383);
        mv(mk(1, 0, 11'h7FF, 11'h002), 1, ev(0, 385, 514));
        chk("wrap_y_down", cur_y, 385);

        // Clamping at the edges.
        mv(mk(1, 0, 11'h7FF, 602), 1, ev(0, 385, 1023));
        chk("clamp_x_max", cur_x, 1023);
        mv(mk(1, 0, 499, 602), 1, ev(0, 0, 1023));
        chk("clamp_y_min", cur_y, 0);
        mv(mk(1, 0, 499, 607), 0, '0);
        chk("clamp_hold_x", cur_x, 1023);
        chk("clamp_no_event", ev_valid, 0);

        // Simultaneous X and Y movement gives one event.
        mv(mk(1, 0, 449, 507), 1, ev(0, 50, 923));
        chk("diag_x", cur_x, 923);
        chk("diag_y", cur_y, 50);

        // Fill the FIFO; the fifth move coalesces into the newest entry.
        ev_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) mv(mk(1, 0, 449, 11'(506 - i)), 1, ev(0, 50, 922 - i));
            else begin
                mv(mk(1, 0, 449, 11'(506 - i)), 0, '0);
                sb[sb.size() - 1] = ev(0, 50, 922 - i);
            end
        end
        chk("full_ovf_clear", ev_overflow, 0);
        chk("full_head", ev_data, ev(0, 50, 922));
        mv(mk(1, 3'b001, 449, 502), 0, '0);
        sb[sb.size() - 1] = ev(3'b001, 50, 918);
        chk("full_ovf_set", ev_overflow, 1);
        ev_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("drained_valid", ev_valid, 0);
        chk("drained_sb", sb.size(), 0);
        chk("ovf_sticky", ev_overflow, 1);

        // Run drop releases buttons and holds the cursor; run rise causes no jump.
        mv(mk(0, 0, 0, 0), 1, ev(0, 50, 918));
        chk("drop_btns", btns, 0);
        chk("drop_run", mouse_run, 0);
        chk("drop_cur_x", cur_x, 918);
        chk("drop_cur_y", cur_y, 50);
        mv(mk(1, 0, 0, 0), 0, '0);
        chk("rise_cur_x", cur_x, 918);
        chk("rise_no_event", ev_valid, 0);
`ifdef MOUSE_ACCEL_EN
        xe = 938;
`else
        xe = 928;
`endif
        mv(mk(1, 0, 0, 10), 1, ev(0, 50, xe));
        chk("accel_x", cur_x, xe);

        // Reset mid-operation with an event pending.
        ev_ready = 1'b0;
        mv(mk(1, 0, 0, 20), 0, '0);
        chk("pending_valid", ev_valid, 1);
        mouse = 28'd0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        chk("rst2_valid", ev_valid, 0);
        chk("rst2_ovf", ev_overflow, 0);
        chk("rst2_cur_x", cur_x, 512);
        chk("rst2_cur_y", cur_y, 384);
        ev_ready = 1'b1;
        mv(mk(1, 0, 0, 0), 0, '0);
        chk("rst2_no_event", ev_valid, 0);
        chk("rst2_hold_x", cur_x, 512);
        chk("end_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
